// File: rtl/sigmoid_inverse_search.sv
// Inverse of the 8-bit percent-scale sigmoid: returns the smallest signed x with s(x) >= p.
// The search runs over u = x + 128 in 0..255 with one bisection step per cycle for 8 cycles.
module sigmoid_inverse_search #(
    parameter int DW    = 8,
    parameter int P_MAX = 99
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] p_in,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] x_out,
    output logic          err,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

    localparam logic [DW-1:0] P_LIMIT = P_MAX[DW-1:0];

    state_t        state, state_next;
    logic [DW-1:0] p_q, p_next;
    logic [8:0]    lo, lo_next;
    logic [8:0]    hi, hi_next;
    logic [8:0]    mid;
    logic [2:0]    cnt, cnt_next;
    logic [DW-1:0] x_q, x_next;
    logic          err_q, err_next;
    logic          reached;

    // Right half of the curve, m = 0..128; everything from 46 upward saturates at 99.
    function automatic logic [6:0] pos_curve(input logic [7:0] m);
        logic [6:0] v;
        case (m) inside
            8'd0:          v = 7'd50;
            8'd1:          v = 7'd52;
            8'd2:          v = 7'd54;
            8'd3:          v = 7'd57;
            8'd4:          v = 7'd59;
            8'd5:          v = 7'd62;
            8'd6:          v = 7'd64;
            8'd7:          v = 7'd66;
            8'd8:          v = 7'd68;
            8'd9:          v = 7'd71;
            8'd10:         v = 7'd73;
            8'd11:         v = 7'd75;
            8'd12:         v = 7'd76;
            8'd13:         v = 7'd78;
            8'd14:         v = 7'd80;
            8'd15:         v = 7'd81;
            8'd16:         v = 7'd83;
            8'd17:         v = 7'd84;
            8'd18:         v = 7'd85;
            8'd19:         v = 7'd86;
            8'd20:         v = 7'd88;
            8'd21:         v = 7'd89;
            [8'd22:8'd23]: v = 7'd90;
            8'd24:         v = 7'd91;
            8'd25:         v = 7'd92;
            [8'd26:8'd27]: v = 7'd93;
            [8'd28:8'd29]: v = 7'd94;
            [8'd30:8'd31]: v = 7'd95;
            [8'd32:8'd34]: v = 7'd96;
            [8'd35:8'd38]: v = 7'd97;
            [8'd39:8'd45]: v = 7'd98;
            default:       v = 7'd99;
        endcase
        return v;
    endfunction

    // Left half uses s(-m) = 99 - s(m); the fractional parts never vanish except at m = 0.
    function automatic logic [6:0] curve(input logic [7:0] x);
        if (!x[7]) return pos_curve(x);
        return 7'd99 - pos_curve(8'd0 - x);
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves a latch.
        state_next = state;
        p_next     = p_q;
        lo_next    = lo;
        hi_next    = hi;
        cnt_next   = cnt;
        x_next     = x_q;
        err_next   = err_q;
        mid        = (lo + hi) >> 1;
        reached    = ({1'b0, curve(mid[7:0] ^ 8'h80)} >= p_q);

        case (state)
            IDLE: begin
                if (in_valid) begin
                    p_next   = p_in;
                    lo_next  = 9'd0;
                    hi_next  = 9'd255;
                    cnt_next = 3'd0;
                    if (p_in > P_LIMIT) begin
                        x_next     = 8'd127;
                        err_next   = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = SEARCH;
                    end
                end
            end
            SEARCH: begin
                if (reached) hi_next = mid;
                else         lo_next = mid + 9'd1;
                cnt_next = cnt + 3'd1;
                if (cnt == 3'd7) begin
                    x_next     = lo_next[7:0] ^ 8'h80;
                    err_next   = 1'b0;
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            p_q   <= '0;
            lo    <= 9'd0;
            hi    <= 9'd255;
            cnt   <= 3'd0;
            x_q   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_next;
            p_q   <= p_next;
            lo    <= lo_next;
            hi    <= hi_next;
            cnt   <= cnt_next;
            x_q   <= x_next;
            err_q <= err_next;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign x_out     = x_q;
    assign err       = err_q;

endmodule
